// File: rtl/mvu_apb_csr.sv
// mvu_apb_csr: APB3 slave holding the per-MVU configuration registers
// of the MVU array and generating the per-MVU start pulse.
module mvu_apb_csr #(
    parameter int NMVU           = 8,
    parameter int BMVUA          = 3,
    parameter int APB_ADDR_WIDTH = 15,
    parameter int APB_DATA_WIDTH = 32,
    parameter int BBWADDR        = 9,
    parameter int BBDADDR        = 9,
    parameter int BSBANKA        = 6,
    parameter int BBBANKA        = 6,
    parameter int BJUMP          = 15,
    parameter int BLENGTH        = 15,
    parameter int NJUMPS         = 5,
    parameter int BPREC          = 6,
    parameter int BCNTDWN        = 29,
    parameter int BQMSBIDX       = 5,
    parameter int BSCALERB       = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [APB_ADDR_WIDTH-1:0]        paddr,
    input  logic [APB_DATA_WIDTH-1:0]        pwdata,
    output logic [APB_DATA_WIDTH-1:0]        prdata,
    output logic                             pready,
    output logic                             pslverr,
    output logic [NMVU*BBWADDR-1:0]          wbaseaddr,
    output logic [NMVU*BBDADDR-1:0]          ibaseaddr,
    output logic [NMVU*BSBANKA-1:0]          sbaseaddr,
    output logic [NMVU*BBBANKA-1:0]          bbaseaddr,
    output logic [NMVU*BBDADDR-1:0]          obaseaddr,
    output logic [NMVU*NJUMPS*BJUMP-1:0]     wjump,
    output logic [NMVU*NJUMPS*BJUMP-1:0]     ijump,
    output logic [NMVU*NJUMPS*BJUMP-1:0]     sjump,
    output logic [NMVU*NJUMPS*BJUMP-1:0]     bjump,
    output logic [NMVU*NJUMPS*BJUMP-1:0]     ojump,
    output logic [NMVU*NJUMPS*BLENGTH-1:0]   wlength,
    output logic [NMVU*NJUMPS*BLENGTH-1:0]   ilength,
    output logic [NMVU*NJUMPS*BLENGTH-1:0]   slength,
    output logic [NMVU*NJUMPS*BLENGTH-1:0]   blength,
    output logic [NMVU*NJUMPS*BLENGTH-1:0]   olength,
    output logic [NMVU*BPREC-1:0]            wprecision,
    output logic [NMVU*BPREC-1:0]            iprecision,
    output logic [NMVU*BPREC-1:0]            oprecision,
    output logic [NMVU-1:0]                  w_signed,
    output logic [NMVU-1:0]                  d_signed,
    output logic [NMVU-1:0]                  max_en,
    output logic [NMVU-1:0]                  max_clr,
    output logic [NMVU-1:0]                  max_pool,
    output logic [NMVU-1:0]                  quant_clr,
    output logic [NMVU*BCNTDWN-1:0]          countdown,
    output logic [NMVU*2-1:0]                mul_mode,
    output logic [NMVU*BQMSBIDX-1:0]         quant_msbidx,
    output logic [NMVU*BSCALERB-1:0]        scaler_b,
    output logic [NMVU*NJUMPS-1:0]           shacc_load_sel,
    output logic [NMVU*NJUMPS-1:0]           zigzag_step_sel,
    output logic [NMVU*NMVU-1:0]             omvusel,
    output logic [NMVU-1:0]                  start
);

    localparam int NSET = 5;

    logic              wr, rd;
    logic [BMVUA-1:0]  id;
    logic [11:0]       off;
    logic [8:0]        grp;
    logic [2:0]        sub;

    logic [BBWADDR-1:0]  wba_q [NMVU], wba_d [NMVU];
    logic [BBDADDR-1:0]  iba_q [NMVU], iba_d [NMVU];
    logic [BSBANKA-1:0]  sba_q [NMVU], sba_d [NMVU];
    logic [BBBANKA-1:0]  bba_q [NMVU], bba_d [NMVU];
    logic [BBDADDR-1:0]  oba_q [NMVU], oba_d [NMVU];
    logic [BJUMP-1:0]    jmp_q [NMVU][NSET][NJUMPS];
    logic [BJUMP-1:0]    jmp_d [NMVU][NSET][NJUMPS];
    logic [BLENGTH-1:0]  len_q [NMVU][NSET][NJUMPS];
    logic [BLENGTH-1:0]  len_d [NMVU][NSET][NJUMPS];
    logic [BPREC-1:0]    wpr_q [NMVU], wpr_d [NMVU];
    logic [BPREC-1:0]    ipr_q [NMVU], ipr_d [NMVU];
    logic [BPREC-1:0]    opr_q [NMVU], opr_d [NMVU];
    logic [BCNTDWN-1:0]  cnt_q [NMVU], cnt_d [NMVU];
    logic [1:0]          mul_q [NMVU], mul_d [NMVU];
    logic [BQMSBIDX-1:0] qmsb_q [NMVU], qmsb_d [NMVU];
    logic [BSCALERB-1:0] scb_q [NMVU], scb_d [NMVU];
    logic [NJUMPS-1:0]   shl_q [NMVU], shl_d [NMVU];
    logic [NJUMPS-1:0]   zzs_q [NMVU], zzs_d [NMVU];
    logic [NMVU-1:0]     omv_q [NMVU], omv_d [NMVU];
    logic [NMVU-1:0]     wsgn_q, wsgn_d, dsgn_q, dsgn_d;
    logic [NMVU-1:0]     maxen_q, maxen_d, maxclr_q, maxclr_d;
    logic [NMVU-1:0]     maxpool_q, maxpool_d, qclr_q, qclr_d;
    logic [NMVU-1:0]     start_q, start_d;

    assign wr  = psel & penable & pwrite;
    assign rd  = psel & penable & ~pwrite;
    assign id  = paddr[APB_ADDR_WIDTH-1:12];
    assign off = paddr[11:0];
    assign grp = off[11:3];
    assign sub = off[2:0];

    assign pready  = 1'b1;
    assign pslverr = 1'b0;

    always_comb begin
        wba_d = wba_q; iba_d = iba_q; sba_d = sba_q;
        bba_d = bba_q; oba_d = oba_q;
        jmp_d = jmp_q; len_d = len_q;
        wpr_d = wpr_q; ipr_d = ipr_q; opr_d = opr_q;
        cnt_d = cnt_q; mul_d = mul_q; qmsb_d = qmsb_q;
        scb_d = scb_q; shl_d = shl_q; zzs_d = zzs_q;
        omv_d = omv_q;
        wsgn_d = wsgn_q; dsgn_d = dsgn_q; maxen_d = maxen_q;
        maxclr_d = maxclr_q; maxpool_d = maxpool_q; qclr_d = qclr_q;
        start_d = '0;
        for (int i = 0; i < NMVU; i++) begin
            if (wr && id == BMVUA'(i)) begin
                if (off == 12'h000) wba_d[i] = pwdata[BBWADDR-1:0];
                if (off == 12'h001) iba_d[i] = pwdata[BBDADDR-1:0];
                if (off == 12'h002) sba_d[i] = pwdata[BSBANKA-1:0];
                if (off == 12'h003) bba_d[i] = pwdata[BBBANKA-1:0];
                if (off == 12'h004) oba_d[i] = pwdata[BBDADDR-1:0];
                for (int j = 0; j < NSET; j++) begin
                    for (int k = 0; k < NJUMPS; k++) begin
                        if (grp == 9'(j + 2) && sub == 3'(k))
                            jmp_d[i][j][k] = pwdata[BJUMP-1:0];
                        // length index 0 has no CSR and stays zero
                        if (k != 0 && grp == 9'(j + 7) && sub == 3'(k))
                            len_d[i][j][k] = pwdata[BLENGTH-1:0];
                    end
                end
                if (off == 12'h060) begin
                    wpr_d[i]  = pwdata[0 +: BPREC];
                    ipr_d[i]  = pwdata[6 +: BPREC];
                    opr_d[i]  = pwdata[12 +: BPREC];
                    wsgn_d[i] = pwdata[24];
                    dsgn_d[i] = pwdata[25];
                end
                if (off == 12'h062) begin
                    cnt_d[i]     = pwdata[BCNTDWN-1:0];
                    maxen_d[i]   = pwdata[29];
                    mul_d[i]     = pwdata[31:30];
                    maxclr_d[i]  = 1'b0;
                    maxpool_d[i] = 1'b0;
                    qclr_d[i]    = 1'b0;
                    // a command landing on a live pulse does not extend it
                    start_d[i]   = ~start_q[i];
                end
                if (off == 12'h063) qmsb_d[i] = pwdata[BQMSBIDX-1:0];
                if (off == 12'h064) scb_d[i] = pwdata[BSCALERB-1:0];
                if (off == 12'h065) begin
                    shl_d[i] = pwdata[0 +: NJUMPS];
                    zzs_d[i] = pwdata[5 +: NJUMPS];
                end
                if (off == 12'h066) omv_d[i] = pwdata[NMVU-1:0];
            end
        end
    end

    always_comb begin
        prdata = '0;
        for (int i = 0; i < NMVU; i++) begin
            if (rd && id == BMVUA'(i)) begin
                if (off == 12'h000) prdata = APB_DATA_WIDTH'(wba_q[i]);
                if (off == 12'h001) prdata = APB_DATA_WIDTH'(iba_q[i]);
                if (off == 12'h002) prdata = APB_DATA_WIDTH'(sba_q[i]);
                if (off == 12'h003) prdata = APB_DATA_WIDTH'(bba_q[i]);
                if (off == 12'h004) prdata = APB_DATA_WIDTH'(oba_q[i]);
                for (int j = 0; j < NSET; j++) begin
                    for (int k = 0; k < NJUMPS; k++) begin
                        if (grp == 9'(j + 2) && sub == 3'(k))
                            prdata = APB_DATA_WIDTH'(jmp_q[i][j][k]);
                        if (k != 0 && grp == 9'(j + 7) && sub == 3'(k))
                            prdata = APB_DATA_WIDTH'(len_q[i][j][k]);
                    end
                end
                if (off == 12'h060) begin
                    prdata[0 +: BPREC]  = wpr_q[i];
                    prdata[6 +: BPREC]  = ipr_q[i];
                    prdata[12 +: BPREC] = opr_q[i];
                    prdata[24]          = wsgn_q[i];
                    prdata[25]          = dsgn_q[i];
                end
                if (off == 12'h062) begin
                    prdata[BCNTDWN-1:0] = cnt_q[i];
                    prdata[29]          = maxen_q[i];
                    prdata[31:30]       = mul_q[i];
                end
                if (off == 12'h063) prdata = APB_DATA_WIDTH'(qmsb_q[i]);
                if (off == 12'h064) prdata = APB_DATA_WIDTH'(scb_q[i]);
                if (off == 12'h065) begin
                    prdata[0 +: NJUMPS] = shl_q[i];
                    prdata[5 +: NJUMPS] = zzs_q[i];
                end
                if (off == 12'h066) prdata = APB_DATA_WIDTH'(omv_q[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wba_q <= '{default: '0}; iba_q <= '{default: '0};
            sba_q <= '{default: '0}; bba_q <= '{default: '0};
            oba_q <= '{default: '0};
            jmp_q <= '{default: '0}; len_q <= '{default: '0};
            wpr_q <= '{default: '0}; ipr_q <= '{default: '0};
            opr_q <= '{default: '0}; cnt_q <= '{default: '0};
            mul_q <= '{default: '0}; qmsb_q <= '{default: '0};
            scb_q <= '{default: '0}; shl_q <= '{default: '0};
            zzs_q <= '{default: '0}; omv_q <= '{default: '0};
            wsgn_q <= '0; dsgn_q <= '0; maxen_q <= '0;
            maxclr_q <= '0; maxpool_q <= '0; qclr_q <= '0;
            start_q <= '0;
        end else begin
            wba_q <= wba_d; iba_q <= iba_d; sba_q <= sba_d;
            bba_q <= bba_d; oba_q <= oba_d;
            jmp_q <= jmp_d; len_q <= len_d;
            wpr_q <= wpr_d; ipr_q <= ipr_d; opr_q <= opr_d;
            cnt_q <= cnt_d; mul_q <= mul_d; qmsb_q <= qmsb_d;
            scb_q <= scb_d; shl_q <= shl_d; zzs_q <= zzs_d;
            omv_q <= omv_d;
            wsgn_q <= wsgn_d; dsgn_q <= dsgn_d; maxen_q <= maxen_d;
            maxclr_q <= maxclr_d; maxpool_q <= maxpool_d;
            qclr_q <= qclr_d;
            start_q <= start_d;
        end
    end

    assign w_signed  = wsgn_q;
    assign d_signed  = dsgn_q;
    assign max_en    = maxen_q;
    assign max_clr   = maxclr_q;
    assign max_pool  = maxpool_q;
    assign quant_clr = qclr_q;
    assign start     = start_q;

    for (genvar i = 0; i < NMVU; i++) begin : g_mvu
        assign wbaseaddr[i*BBWADDR +: BBWADDR]       = wba_q[i];
        assign ibaseaddr[i*BBDADDR +: BBDADDR]       = iba_q[i];
        assign sbaseaddr[i*BSBANKA +: BSBANKA]       = sba_q[i];
        assign bbaseaddr[i*BBBANKA +: BBBANKA]       = bba_q[i];
        assign obaseaddr[i*BBDADDR +: BBDADDR]       = oba_q[i];
        assign wprecision[i*BPREC +: BPREC]          = wpr_q[i];
        assign iprecision[i*BPREC +: BPREC]          = ipr_q[i];
        assign oprecision[i*BPREC +: BPREC]          = opr_q[i];
        assign countdown[i*BCNTDWN +: BCNTDWN]       = cnt_q[i];
        assign mul_mode[i*2 +: 2]                    = mul_q[i];
        assign quant_msbidx[i*BQMSBIDX +: BQMSBIDX]  = qmsb_q[i];
        assign scaler_b[i*BSCALERB +: BSCALERB]      = scb_q[i];
        assign shacc_load_sel[i*NJUMPS +: NJUMPS]    = shl_q[i];
        assign zigzag_step_sel[i*NJUMPS +: NJUMPS]   = zzs_q[i];
        assign omvusel[i*NMVU +: NMVU]               = omv_q[i];
        for (genvar k = 0; k < NJUMPS; k++) begin : g_k
            localparam int JB = (i*NJUMPS + k) * BJUMP;
            localparam int LB = (i*NJUMPS + k) * BLENGTH;
            assign wjump[JB +: BJUMP]     = jmp_q[i][0][k];
            assign ijump[JB +: BJUMP]     = jmp_q[i][1][k];
            assign sjump[JB +: BJUMP]     = jmp_q[i][2][k];
            assign bjump[JB +: BJUMP]     = jmp_q[i][3][k];
            assign ojump[JB +: BJUMP]     = jmp_q[i][4][k];
            assign wlength[LB +: BLENGTH] = len_q[i][0][k];
            assign ilength[LB +: BLENGTH] = len_q[i][1][k];
            assign slength[LB +: BLENGTH] = len_q[i][2][k];
            assign blength[LB +: BLENGTH] = len_q[i][3][k];
            assign olength[LB +: BLENGTH] = len_q[i][4][k];
        end
    end

endmodule

// File: tb/tb_mvu_apb_csr.sv
// Bench for mvu_apb_csr: address-map model plus directed APB traffic
// on a 4-MVU instance.
module tb_mvu_apb_csr;

    localparam int NM = 4;

    logic clk, rst, psel, penable, pwrite;
    logic [14:0] paddr;
    logic [31:0] pwdata, prdata;
    logic pready, pslverr;
    logic [NM*9-1:0] wbaseaddr, ibaseaddr, obaseaddr;
    logic [NM*6-1:0] sbaseaddr, bbaseaddr;
    logic [NM*75-1:0] wjump, ijump, sjump, bjump, ojump;
    logic [NM*75-1:0] wlength, ilength, slength, blength, olength;
    logic [NM*6-1:0] wprecision, iprecision, oprecision;
    logic [NM-1:0] w_signed, d_signed, max_en, max_clr, max_pool;
    logic [NM-1:0] quant_clr, start;
    logic [NM*29-1:0] countdown;
    logic [NM*2-1:0] mul_mode;
    logic [NM*5-1:0] quant_msbidx, shacc_load_sel, zigzag_step_sel;
    logic [NM*16-1:0] scaler_b;
    logic [NM*NM-1:0] omvusel;

    mvu_apb_csr #(.NMVU(NM)) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .wbaseaddr(wbaseaddr), .ibaseaddr(ibaseaddr),
        .sbaseaddr(sbaseaddr), .bbaseaddr(bbaseaddr),
        .obaseaddr(obaseaddr),
        .wjump(wjump), .ijump(ijump), .sjump(sjump),
        .bjump(bjump), .ojump(ojump),
        .wlength(wlength), .ilength(ilength), .slength(slength),
        .blength(blength), .olength(olength),
        .wprecision(wprecision), .iprecision(iprecision),
        .oprecision(oprecision),
        .w_signed(w_signed), .d_signed(d_signed), .max_en(max_en),
        .max_clr(max_clr), .max_pool(max_pool), .quant_clr(quant_clr),
        .countdown(countdown), .mul_mode(mul_mode),
        .quant_msbidx(quant_msbidx), .scaler_b(scaler_b),
        .shacc_load_sel(shacc_load_sel),
        .zigzag_step_sel(zigzag_step_sel),
        .omvusel(omvusel), .start(start)
    );

    int total = 0;
    int bad = 0;

    // model: register contents by address, as they read back
    logic [31:0] mreg [int];
    logic [NM-1:0] exp_start, nxt_start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] mask(input int o);
        int g, s;
        g = o >> 3;
        s = o & 7;
        if (o <= 4) return (o == 2 || o == 3) ? 32'h3F : 32'h1FF;
        if (g >= 2 && g <= 6 && s < 5) return 32'h7FFF;
        if (g >= 7 && g <= 11 && s >= 1 && s <= 4) return 32'h7FFF;
        case (o)
            'h60: return 32'h0303_FFFF;
            'h62: return 32'hFFFF_FFFF;
            'h63: return 32'h1F;
            'h64: return 32'hFFFF;
            'h65: return 32'h3FF;
            'h66: return (32'd1 << NM) - 1;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] mv(input int i, input int o);
        int key;
        key = i * 4096 + o;
        if (i < NM && mreg.exists(key)) return mreg[key];
        return 32'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mreg.delete();
            exp_start = '0;
        end else begin
            nxt_start = '0;
            if (psel && penable && pwrite && int'(paddr[14:12]) < NM) begin
                if (mask(int'(paddr[11:0])) != 0)
                    mreg[int'(paddr[14:12]) * 4096 + int'(paddr[11:0])] =
                        pwdata & mask(int'(paddr[11:0]));
                if (paddr[11:0] == 12'h062)
                    nxt_start[paddr[13:12]] = !exp_start[paddr[13:12]];
            end
            exp_start = nxt_start;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            logic [31:0] p, c, f;
            chk("pready", 64'(pready), 64'd1);
            chk("pslverr", 64'(pslverr), 64'd0);
            chk("prdata", 64'(prdata),
                (psel && penable && !pwrite) ?
                64'(mv(int'(paddr[14:12]), int'(paddr[11:0]))) : 64'd0);
            chk("start", 64'(start), 64'(exp_start));
            for (int i = 0; i < NM; i++) begin
                chk("wbase", 64'(wbaseaddr[i*9 +: 9]), 64'(mv(i, 'h0)));
                chk("ibase", 64'(ibaseaddr[i*9 +: 9]), 64'(mv(i, 'h1)));
                chk("sbase", 64'(sbaseaddr[i*6 +: 6]), 64'(mv(i, 'h2)));
                chk("bbase", 64'(bbaseaddr[i*6 +: 6]), 64'(mv(i, 'h3)));
                chk("obase", 64'(obaseaddr[i*9 +: 9]), 64'(mv(i, 'h4)));
                for (int k = 0; k < 5; k++) begin
                    int b;
                    b = (i*5 + k) * 15;
                    chk("wjump", 64'(wjump[b +: 15]), 64'(mv(i, 'h10 + k)));
                    chk("ijump", 64'(ijump[b +: 15]), 64'(mv(i, 'h18 + k)));
                    chk("sjump", 64'(sjump[b +: 15]), 64'(mv(i, 'h20 + k)));
                    chk("bjump", 64'(bjump[b +: 15]), 64'(mv(i, 'h28 + k)));
                    chk("ojump", 64'(ojump[b +: 15]), 64'(mv(i, 'h30 + k)));
                    chk("wlen", 64'(wlength[b +: 15]), 64'(mv(i, 'h38 + k)));
                    chk("ilen", 64'(ilength[b +: 15]), 64'(mv(i, 'h40 + k)));
                    chk("slen", 64'(slength[b +: 15]), 64'(mv(i, 'h48 + k)));
                    chk("blen", 64'(blength[b +: 15]), 64'(mv(i, 'h50 + k)));
                    chk("olen", 64'(olength[b +: 15]), 64'(mv(i, 'h58 + k)));
                end
                p = mv(i, 'h60);
                c = mv(i, 'h62);
                f = mv(i, 'h65);
                chk("wprec", 64'(wprecision[i*6 +: 6]), 64'(p[5:0]));
                chk("iprec", 64'(iprecision[i*6 +: 6]), 64'(p[11:6]));
                chk("oprec", 64'(oprecision[i*6 +: 6]), 64'(p[17:12]));
                chk("wsgn", 64'(w_signed[i]), 64'(p[24]));
                chk("dsgn", 64'(d_signed[i]), 64'(p[25]));
                chk("cntdwn", 64'(countdown[i*29 +: 29]), 64'(c[28:0]));
                chk("maxen", 64'(max_en[i]), 64'(c[29]));
                chk("mulmode", 64'(mul_mode[i*2 +: 2]), 64'(c[31:30]));
                chk("clrs", 64'({max_clr[i], max_pool[i], quant_clr[i]}),
                    64'd0);
                chk("qmsb", 64'(quant_msbidx[i*5 +: 5]), 64'(mv(i, 'h63)));
                chk("scaler", 64'(scaler_b[i*16 +: 16]), 64'(mv(i, 'h64)));
                chk("shacc", 64'(shacc_load_sel[i*5 +: 5]), 64'(f[4:0]));
                chk("zigzag", 64'(zigzag_step_sel[i*5 +: 5]), 64'(f[9:5]));
                chk("omvusel", 64'(omvusel[i*NM +: NM]), 64'(mv(i, 'h66)));
            end
        end
    end

    task automatic apb_wr(input logic [14:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [14:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #2 d = prdata;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    logic [31:0] rdv;

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_start", 64'(start), 64'd0);
        chk("rst_prdata", 64'(prdata), 64'd0);

        for (int o = 0; o < 'h70; o++) begin
            apb_rd(15'(o), rdv);
            chk("rst_rd0", 64'(rdv), 64'd0);
            apb_rd(15'h7000 | 15'(o), rdv);
            chk("rst_rd7", 64'(rdv), 64'd0);
        end

        apb_wr(15'h3001, 32'h1A5);
        chk("ibase3", 64'(ibaseaddr), 64'h1A5 << 27);
        apb_rd(15'h3001, rdv);
        chk("ibase3_rd", 64'(rdv), 64'h1A5);

        apb_wr(15'h1060, 32'h0300_2082);
        chk("wprec1", 64'(wprecision[6 +: 6]), 64'd2);
        chk("iprec1", 64'(iprecision[6 +: 6]), 64'd2);
        chk("oprec1", 64'(oprecision[6 +: 6]), 64'd2);
        chk("wsgn1", 64'(w_signed), 64'b0010);
        chk("dsgn1", 64'(d_signed), 64'b0010);

        // two COMMAND strobes on consecutive cycles to MVU 2
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = 15'h2062; pwdata = 32'h6000_0010;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        chk("start2", 64'(start), 64'b0100);
        chk("cnt2", 64'(countdown[58 +: 29]), 64'd16);
        chk("maxen2", 64'(max_en), 64'b0100);
        chk("mul2", 64'(mul_mode[4 +: 2]), 64'd1);
        pwdata = 32'h0000_0020;
        @(posedge clk); #1;
        chk("start2_b2b", 64'(start), 64'd0);
        chk("cnt2_b2b", 64'(countdown[58 +: 29]), 64'd32);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        chk("start2_idle", 64'(start), 64'd0);

        apb_wr(15'h0062, 32'h0000_0005);
        chk("start0", 64'(start), 64'b0001);
        @(posedge clk); #1;
        chk("start0_end", 64'(start), 64'd0);

        apb_wr(15'h2049, 32'h55);
        apb_wr(15'h204C, 32'h55);
        apb_wr(15'h2048, 32'h55);
        chk("slen21", 64'(slength[165 +: 15]), 64'h55);
        chk("slen24", 64'(slength[210 +: 15]), 64'h55);
        chk("slen22", 64'(slength[180 +: 15]), 64'd0);
        chk("slen20", 64'(slength[150 +: 15]), 64'd0);
        apb_rd(15'h2048, rdv);
        chk("slen20_rd", 64'(rdv), 64'd0);

        apb_wr(15'h00FF, 32'hFFFF_FFFF);
        apb_wr(15'h7001, 32'h1FF);
        chk("drop_ibase", 64'(ibaseaddr), 64'h1A5 << 27);
        chk("drop_pready", 64'(pready), 64'd1);
        chk("drop_pslverr", 64'(pslverr), 64'd0);
        apb_rd(15'h7001, rdv);
        chk("drop_rd7", 64'(rdv), 64'd0);

        for (int o = 0; o < 'h70; o++)
            apb_wr(15'h1000 | 15'(o), 32'hA5C3_96F0 ^ (32'(o) * 32'h0101_0101));
        for (int o = 0; o < 'h70; o++)
            apb_rd(15'h1000 | 15'(o), rdv);
        apb_rd(15'h1062, rdv);
        chk("cmd1_rd", 64'(rdv), 64'hA5C3_96F0 ^ 64'h6262_6262);

        // reset landing on a live COMMAND access phase
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0;
        paddr = 15'h3062; pwdata = 32'h0000_0077;
        @(posedge clk); #1 penable = 1'b1;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_start", 64'(start), 64'd0);
        chk("rstmid_cnt", 64'(countdown), 64'd0);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_start2", 64'(start), 64'd0);
        chk("rstmid_ibase", 64'(ibaseaddr), 64'd0);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
